// File: rtl/pong_game_ctrl_if.sv
// Ball/racket positions and game-status outputs exchanged between the pong
// game controller (slave) and whatever feeds and observes it (master).
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] racket_x;
    logic [9:0] racket_y;
    logic       ball_hold;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output frame_tick, btn_start, ball_x, ball_y, racket_x, racket_y,
        input  ball_hold, score_bcd, lives, game_over, state
    );

    modport slave (
        input  frame_tick, btn_start, ball_x, ball_y, racket_x, racket_y,
        output ball_hold, score_bcd, lives, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: hit/miss detection, BCD score, lives, serve/miss ball hold.
// Latency: state/score/lives update on the clk edge sampling frame_tick; no backpressure.
module pong_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int RACKET_H    = 40,
    parameter int MISS_X      = 2,
    parameter int REARM_DX    = 16,
    parameter int HOLD_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset,
    pong_game_ctrl_if.slave bus
);
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_MISS      = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     score_q, score_d;
    logic [1:0]     lives_q, lives_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           armed_q, armed_d;
    logic           start_d;

    logic           start_edge;
    logic [10:0]    span_hi;
    logic [10:0]    rearm_x;
    logic           is_miss;
    logic           is_hit;
    logic           is_rearm;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        if (s != 8'h99) begin
            if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
            else                r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign start_edge = bus.btn_start & ~start_d;

    // 11-bit sums so a racket near the bottom/right edge does not wrap
    assign span_hi  = {1'b0, bus.racket_y} + 11'(RACKET_H);
    assign rearm_x  = {1'b0, bus.racket_x} + 11'(REARM_DX);
    assign is_miss  = bus.ball_x <= 10'(MISS_X);
    assign is_hit   = armed_q && (bus.ball_x <= bus.racket_x) &&
                      (bus.ball_y >= bus.racket_y) && ({1'b0, bus.ball_y} <= span_hi);
    assign is_rearm = {1'b0, bus.ball_x} > rearm_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            score_q <= 8'h00;
            lives_q <= 2'(LIVES);
            hold_q  <= '0;
            armed_q <= 1'b1;
            start_d <= 1'b1;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hold_q  <= hold_d;
            armed_q <= armed_d;
            start_d <= bus.btn_start;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        armed_d = armed_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_SERVE;
                    hold_d  = '0;
                    score_d = 8'h00;
                    lives_d = 2'(LIVES);
                    armed_d = 1'b1;
                end
            end
            S_SERVE, S_MISS: begin
                if (bus.frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_PLAY;
                        hold_d  = '0;
                        armed_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    // a miss takes priority and suppresses any same-tick hit
                    if (is_miss) begin
                        lives_d = lives_q - 2'd1;
                        hold_d  = '0;
                        state_d = (lives_q == 2'd1) ? S_GAME_OVER : S_MISS;
                    end else begin
                        if (is_hit) begin
                            score_d = bcd_inc(score_q);
                            armed_d = 1'b0;
                        end
                        if (is_rearm) armed_d = 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.ball_hold = (state_q != S_PLAY);
    assign bus.game_over = (state_q == S_GAME_OVER);
    assign bus.score_bcd = score_q;
    assign bus.lives     = lives_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: decimal-count game model checked every cycle,
// plus literal expectations at each scenario milestone.
module tb_pong_game_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model: state as a number, score as a plain decimal hit count.
    int m_st, m_score, m_lives, m_hold;
    bit m_armed, m_prev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= 0; m_score <= 0; m_lives <= 3; m_hold <= 0; m_armed <= 1; m_prev <= 1;
        end else begin
            m_prev <= bus.btn_start;
            if (m_st == 0) begin
                if (bus.btn_start && !m_prev) begin
                    m_st <= 1; m_hold <= 0; m_score <= 0; m_lives <= 3; m_armed <= 1;
                end
            end else if (m_st == 1 || m_st == 3) begin
                if (bus.frame_tick) begin
                    if (m_hold + 1 == 60) begin
                        m_st <= 2; m_hold <= 0; m_armed <= 1;
                    end else m_hold <= m_hold + 1;
                end
            end else if (m_st == 2) begin
                if (bus.frame_tick) begin
                    if (int'(bus.ball_x) <= 2) begin
                        m_lives <= m_lives - 1;
                        m_hold  <= 0;
                        m_st    <= (m_lives - 1 == 0) ? 4 : 3;
                    end else if (m_armed && bus.ball_x <= bus.racket_x &&
                                 int'(bus.ball_y) >= int'(bus.racket_y) &&
                                 int'(bus.ball_y) <= int'(bus.racket_y) + 40) begin
                        m_score <= (m_score < 99) ? m_score + 1 : 99;
                        m_armed <= 0;
                    end else if (int'(bus.ball_x) > int'(bus.racket_x) + 16) begin
                        m_armed <= 1;
                    end
                end
            end else if (m_st == 4) begin
                if (bus.btn_start && !m_prev) m_st <= 0;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) + (s % 10));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        checks++;
        if (bus.state != 3'(m_st) || bus.score_bcd != to_bcd(m_score) ||
            bus.lives != 2'(m_lives) || bus.ball_hold != (m_st != 2) ||
            bus.game_over != (m_st == 4)) begin
            failures++;
            $display("FAIL model: got st=%0d sc=%h lv=%0d hold=%0b go=%0b expected st=%0d sc=%h lv=%0d hold=%0b go=%0b at %0t",
                     bus.state, bus.score_bcd, bus.lives, bus.ball_hold, bus.game_over,
                     m_st, to_bcd(m_score), m_lives, (m_st != 2), (m_st == 4), $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        bus.btn_start = 1'b1;
        cyc();
        bus.btn_start = 1'b0;
        cyc();
    endtask

    task automatic hit();
        bus.ball_x = 10'd30;
        tick();
        bus.ball_x = 10'd10;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_start  = 1'b1;
        bus.ball_x     = 10'd320;
        bus.ball_y     = 10'd240;
        bus.racket_x   = 10'd10;
        bus.racket_y   = 10'd200;

        // T1: button held through reset release does not start
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) cyc();
        chk("t1_state", bus.state, 0);
        chk("t1_hold", bus.ball_hold, 1);
        chk("t1_score", bus.score_bcd, 8'h00);
        chk("t1_lives", bus.lives, 3);
        bus.btn_start = 1'b0;
        cyc();

        // T2: serve hold lasts 60 ticks
        press();
        chk("t2_serve", bus.state, 1);
        ticks(59);
        chk("t2_still_serve", bus.state, 1);
        tick();
        chk("t2_play", bus.state, 2);
        chk("t2_hold_low", bus.ball_hold, 0);

        // start edge ignored in PLAY
        press();
        chk("play_ignores_start", bus.state, 2);

        // T3: hit counted once until re-armed
        bus.ball_x = 10'd10;
        bus.ball_y = 10'd220;
        tick();
        tick();
        chk("t3_once", bus.score_bcd, 8'h01);
        hit();
        chk("t3_rearm", bus.score_bcd, 8'h02);

        // T4: BCD carry and saturation
        repeat (7) hit();
        chk("t4_09", bus.score_bcd, 8'h09);
        hit();
        chk("t4_10", bus.score_bcd, 8'h10);
        repeat (89) hit();
        chk("t4_99", bus.score_bcd, 8'h99);
        hit();
        chk("t4_sat", bus.score_bcd, 8'h99);

        // T5: misses down to game over
        bus.ball_x = 10'd2;
        bus.ball_y = 10'd300;
        tick();
        chk("t5_lives2", bus.lives, 2);
        chk("t5_miss", bus.state, 3);
        chk("t5_hold", bus.ball_hold, 1);
        bus.ball_x = 10'd320;
        ticks(59);
        chk("t5_still_miss", bus.state, 3);
        tick();
        chk("t5_replay", bus.state, 2);
        bus.ball_x = 10'd2;
        tick();
        chk("t5_lives1", bus.lives, 1);
        bus.ball_x = 10'd320;
        ticks(60);
        bus.ball_x = 10'd2;
        tick();
        chk("t5_gameover", bus.state, 4);
        chk("t5_go_flag", bus.game_over, 1);
        chk("t5_lives0", bus.lives, 0);
        tick();
        chk("t5_frozen", bus.score_bcd, 8'h99);
        press();
        chk("t5_idle", bus.state, 0);
        chk("t5_idle_score", bus.score_bcd, 8'h99);

        // T6: async reset mid-MISS
        bus.ball_x = 10'd320;
        press();
        chk("t6_cleared_score", bus.score_bcd, 8'h00);
        chk("t6_cleared_lives", bus.lives, 3);
        ticks(60);
        bus.ball_x = 10'd2;
        tick();
        bus.ball_x = 10'd320;
        ticks(30);
        chk("t6_in_miss", bus.state, 3);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_state", bus.state, 0);
        chk("t6_async_hold", bus.ball_hold, 1);
        chk("t6_async_lives", bus.lives, 3);
        chk("t6_async_score", bus.score_bcd, 8'h00);
        check_model();
        cyc();
        reset = 1'b0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
